// File: rtl/color_pkg.sv
// color_pkg
// Shared definitions for the colour seeker:
//   - state-index constants IDLE_S..WHITE_S (mixer state numbers 0..7)
//   - active-high RGB colour codes IDLE..WHITE, bit2=red, bit1=green, bit0=blue
//   - seek_state_t, the seeker FSM state enum
package color_pkg;

    // Mixer state indices
    localparam logic [2:0] IDLE_S    = 3'd0;
    localparam logic [2:0] RED_S     = 3'd1;
    localparam logic [2:0] GREEN_S   = 3'd2;
    localparam logic [2:0] BLUE_S    = 3'd3;
    localparam logic [2:0] YELLOW_S  = 3'd4;
    localparam logic [2:0] CYAN_S    = 3'd5;
    localparam logic [2:0] MAGENTA_S = 3'd6;
    localparam logic [2:0] WHITE_S   = 3'd7;

    // Active-high LED colour codes {r,g,b}
    localparam logic [2:0] IDLE    = 3'b000;
    localparam logic [2:0] RED     = 3'b100;
    localparam logic [2:0] GREEN   = 3'b010;
    localparam logic [2:0] BLUE    = 3'b001;
    localparam logic [2:0] YELLOW  = 3'b110;
    localparam logic [2:0] CYAN    = 3'b011;
    localparam logic [2:0] MAGENTA = 3'b101;
    localparam logic [2:0] WHITE   = 3'b111;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_PRESS,
        ST_GAP,
        ST_DONE,
        ST_ERR
    } seek_state_t;

endpackage

// File: rtl/cycle_timer.sv
// cycle_timer
// Loadable down-counter. Loading value V makes done go high V cycles later
// (done is high immediately for V=0), so a state that loads N-1 on entry and
// leaves on done lasts exactly N cycles. The counter parks at zero.
// Ports:
//   clk, rst_n  clock, synchronous active-low reset
//   load        load load_val this cycle (wins over counting)
//   load_val    value to load
//   done        count has reached zero
module cycle_timer #(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (!rst_n)
            count <= '0;
        else if (load)
            count <= load_val;
        else if (count != '0)
            count <= count - 1'b1;
    end

    assign done = (count == '0);

endmodule

// File: rtl/color_seeker.sv
// color_seeker
// Drives a colour mixer's push-button until the mixer's LEDs show the
// requested state, or gives up after NUM_STATES presses.
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   req_i        start request (accepted only when idle)
//   target_i     target state index, sampled with an accepted request
//   rgb_n_i      active-low LED feedback {r,g,b}
//   sw_o         synthetic button press, high for PRESS_CYCLES per press
//   busy_o       request in progress
//   done_o       one-cycle pulse: target reached
//   err_o        one-cycle pulse: target out of range or never reached
//   presses_o    presses issued for the current/last request
//   cur_state_o  registered state index decoded from rgb_n_i
module color_seeker
    import color_pkg::*;
#(
    parameter int NUM_STATES   = 8,
    parameter int PRESS_CYCLES = 16,
    parameter int GAP_CYCLES   = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_i,
    input  logic [2:0] target_i,
    input  logic [2:0] rgb_n_i,
    output logic       sw_o,
    output logic       busy_o,
    output logic       done_o,
    output logic       err_o,
    output logic [3:0] presses_o,
    output logic [2:0] cur_state_o
);

    localparam int MAX_CYC = (PRESS_CYCLES > GAP_CYCLES) ? PRESS_CYCLES : GAP_CYCLES;
    localparam int TW      = $clog2(MAX_CYC + 1);
    localparam logic [TW-1:0] PRESS_LOAD = TW'(PRESS_CYCLES - 1);
    localparam logic [TW-1:0] GAP_LOAD   = TW'(GAP_CYCLES - 1);
    localparam logic [3:0]    MAX_PRESS  = 4'(NUM_STATES);

    seek_state_t   state_q, state_d;
    logic [2:0]    target_q;
    logic [2:0]    color;
    logic [2:0]    decoded;
    logic          tmr_load;
    logic [TW-1:0] tmr_val;
    logic          tmr_done;
    logic          press_inc;

    // LED colour -> mixer state index
    assign color = ~rgb_n_i;

    always_comb begin
        decoded = IDLE_S;
        case (color)
            IDLE:    decoded = IDLE_S;
            RED:     decoded = RED_S;
            GREEN:   decoded = GREEN_S;
            BLUE:    decoded = BLUE_S;
            YELLOW:  decoded = YELLOW_S;
            CYAN:    decoded = CYAN_S;
            MAGENTA: decoded = MAGENTA_S;
            WHITE:   decoded = WHITE_S;
            default: decoded = IDLE_S;
        endcase
    end

    cycle_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .done     (tmr_done)
    );

    always_comb begin
        state_d   = state_q;
        tmr_load  = 1'b0;
        tmr_val   = '0;
        press_inc = 1'b0;
        case (state_q)
            ST_IDLE:
                if (req_i) state_d = ST_CHECK;
            ST_CHECK: begin
                // The range check runs on the latched target in the first
                // CHECK cycle, so a bad target errors with the same two-cycle
                // latency as a target that is already showing.
                if ({1'b0, target_q} >= MAX_PRESS)
                    state_d = ST_ERR;
                else if (cur_state_o == target_q)
                    state_d = ST_DONE;
                else if (presses_o == MAX_PRESS)
                    state_d = ST_ERR;
                else begin
                    state_d   = ST_PRESS;
                    tmr_load  = 1'b1;
                    tmr_val   = PRESS_LOAD;
                    press_inc = 1'b1;
                end
            end
            ST_PRESS:
                if (tmr_done) begin
                    state_d  = ST_GAP;
                    tmr_load = 1'b1;
                    tmr_val  = GAP_LOAD;
                end
            ST_GAP:
                if (tmr_done) state_d = ST_CHECK;
            ST_DONE:  state_d = ST_IDLE;
            ST_ERR:   state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            target_q    <= '0;
            presses_o   <= '0;
            cur_state_o <= '0;
        end else begin
            state_q     <= state_d;
            cur_state_o <= decoded;
            if (state_q == ST_IDLE && req_i) begin
                target_q  <= target_i;
                presses_o <= '0;
            end else if (press_inc && presses_o != MAX_PRESS) begin
                presses_o <= presses_o + 4'd1;
            end
        end
    end

    // Outputs decode straight from the state register, so sw_o drops on the
    // first reset edge.
    assign sw_o   = (state_q == ST_PRESS);
    assign busy_o = (state_q != ST_IDLE);
    assign done_o = (state_q == ST_DONE);
    assign err_o  = (state_q == ST_ERR);

endmodule

// File: tb/tb_color_seeker.sv
module tb_color_seeker;

    localparam int P = 16;
    localparam int G = 32;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_i = 1'b0;
    logic [2:0] target_i = 3'd0;
    logic [2:0] rgb_n_i;
    logic       sw_o, busy_o, done_o, err_o;
    logic [3:0] presses_o;
    logic [2:0] cur_state_o;

    // second instance with a 6-state mixer, LEDs fixed at red
    logic       req6 = 1'b0;
    logic [2:0] target6 = 3'd0;
    logic [2:0] rgb_n6;
    logic       sw6, busy6, done6, err6;
    logic [3:0] presses6;
    logic [2:0] cur6;
    assign rgb_n6 = 3'b011;

    always #5 clk = ~clk;

    color_seeker #(.NUM_STATES(8), .PRESS_CYCLES(P), .GAP_CYCLES(G)) dut (
        .clk(clk), .rst_n(rst_n), .req_i(req_i), .target_i(target_i),
        .rgb_n_i(rgb_n_i), .sw_o(sw_o), .busy_o(busy_o), .done_o(done_o),
        .err_o(err_o), .presses_o(presses_o), .cur_state_o(cur_state_o));

    color_seeker #(.NUM_STATES(6), .PRESS_CYCLES(P), .GAP_CYCLES(G)) dut6 (
        .clk(clk), .rst_n(rst_n), .req_i(req6), .target_i(target6),
        .rgb_n_i(rgb_n6), .sw_o(sw6), .busy_o(busy6), .done_o(done6),
        .err_o(err6), .presses_o(presses6), .cur_state_o(cur6));

    // behavioural mixer: advances one state per rising edge of sw_o
    function automatic logic [2:0] color_of(input int idx);
        case (idx)
            0: return 3'b000;
            1: return 3'b100;
            2: return 3'b010;
            3: return 3'b001;
            4: return 3'b110;
            5: return 3'b011;
            6: return 3'b101;
            default: return 3'b111;
        endcase
    endfunction

    int   mstate = 0;
    bit   stuck = 1'b0;
    bit   mix_set = 1'b0;
    int   mix_val = 0;
    logic sw_prev = 1'b0;

    always @(posedge clk) begin
        sw_prev <= sw_o;
        if (mix_set)
            mstate <= mix_val;
        else if (sw_o && !sw_prev)
            mstate <= (mstate + 1) % 8;
    end

    assign rgb_n_i = stuck ? 3'b111 : ~color_of(mstate);

    int checks = 0;
    int fails  = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        string name;
        bit    done;
        bit    err;
        int    presses;
        int    lat;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        int         mix;
        bit         stk;
        logic [2:0] tgt;
        bit         exp_done;
        bit         exp_err;
        int         exp_presses;
    } vec_t;
    vec_t vecs[6];

    task automatic set_mixer(input int mix, input bit stk);
        stuck   = stk;
        mix_set = 1'b1;
        mix_val = mix;
        @(negedge clk);
        mix_set = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    // Runs one request on the 8-state DUT. glitch_k>0 fires a second req_i
    // with a different target k cycles in, which must be ignored.
    task automatic do_req(input string name, input int mix, input bit stk,
                          input logic [2:0] tgt, input bit ed, input bit ee,
                          input int ep, input int glitch_k);
        exp_t e;
        int k, hi, lo, rises, bad_w;
        bit seen, both;
        set_mixer(mix, stk);
        e.name = name; e.done = ed; e.err = ee; e.presses = ep;
        // each press round is PRESS + GAP + one CHECK cycle
        e.lat = 2 + ep * (P + G + 1);
        sb.push_back(e);
        req_i = 1'b1; target_i = tgt;
        k = 0; hi = 0; lo = -1; rises = 0; bad_w = 0; seen = 0; both = 0;
        while (!seen && k < 2000) begin
            @(negedge clk); k++;
            if (k == 1) begin req_i = 1'b0; target_i = 3'd0; end
            if (glitch_k != 0 && k == glitch_k) begin req_i = 1'b1; target_i = ~tgt; end
            if (glitch_k != 0 && k == glitch_k + 1) req_i = 1'b0;
            if (sw_o) begin
                if (hi == 0) begin
                    rises++;
                    // low time between presses: GAP plus the CHECK cycle
                    if (lo >= 0 && lo != G + 1) bad_w++;
                end
                hi++;
            end else begin
                if (hi > 0) begin
                    if (hi != P) bad_w++;
                    hi = 0; lo = 0;
                end
                if (lo >= 0) lo++;
            end
            if (done_o && err_o) both = 1'b1;
            if (done_o || err_o) seen = 1'b1;
        end
        e = sb.pop_front();
        check({e.name, " finished in budget"}, int'(seen), 1);
        check({e.name, " done_o"}, int'(done_o), int'(e.done));
        check({e.name, " err_o"}, int'(err_o), int'(e.err));
        check({e.name, " presses_o"}, int'(presses_o), e.presses);
        check({e.name, " latency"}, k, e.lat);
        check({e.name, " sw pulses"}, rises, e.presses);
        check({e.name, " press/gap widths bad"}, bad_w, 0);
        check({e.name, " done&err overlap"}, int'(both), 0);
        @(negedge clk);
        check({e.name, " busy after"}, int'(busy_o), 0);
        check({e.name, " pulse one cycle"}, int'(done_o | err_o), 0);
        check({e.name, " presses held"}, int'(presses_o), e.presses);
    endtask

    task automatic do_req6(input string name, input logic [2:0] tgt, input bit ed, input bit ee);
        exp_t e;
        int k, rises;
        bit seen;
        e.name = name; e.done = ed; e.err = ee; e.presses = 0; e.lat = 2;
        sb.push_back(e);
        req6 = 1'b1; target6 = tgt;
        k = 0; rises = 0; seen = 0;
        while (!seen && k < 200) begin
            @(negedge clk); k++;
            if (k == 1) req6 = 1'b0;
            if (sw6) rises++;
            if (done6 || err6) seen = 1'b1;
        end
        e = sb.pop_front();
        check({e.name, " finished in budget"}, int'(seen), 1);
        check({e.name, " done_o"}, int'(done6), int'(e.done));
        check({e.name, " err_o"}, int'(err6), int'(e.err));
        check({e.name, " latency"}, k, e.lat);
        check({e.name, " sw high cycles"}, rises, 0);
        check({e.name, " presses_o"}, int'(presses6), e.presses);
        @(negedge clk);
        check({e.name, " busy after"}, int'(busy6), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, hi, sw_seen;
        //          mix stk tgt   done err presses
        vecs[0] = '{1, 0, 3'd1, 1, 0, 0};   // already red
        vecs[1] = '{1, 0, 3'd4, 1, 0, 3};
        vecs[2] = '{7, 0, 3'd0, 1, 0, 1};   // wrap 7 -> 0
        vecs[3] = '{0, 1, 3'd2, 0, 1, 8};   // LEDs stuck off
        vecs[4] = '{0, 0, 3'd7, 1, 0, 7};
        vecs[5] = '{5, 0, 3'd2, 1, 0, 5};

        // reset state
        repeat (3) @(negedge clk);
        check("reset sw_o", int'(sw_o), 0);
        check("reset busy_o", int'(busy_o), 0);
        check("reset done_o", int'(done_o), 0);
        check("reset err_o", int'(err_o), 0);
        check("reset presses_o", int'(presses_o), 0);
        check("reset cur_state_o", int'(cur_state_o), 0);
        check("reset busy6", int'(busy6), 0);
        check("reset cur6", int'(cur6), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // colour decode of every mixer state
        for (int s = 0; s < 8; s++) begin
            set_mixer(s, 1'b0);
            check($sformatf("decode state %0d", s), int'(cur_state_o), s);
        end

        for (int i = 0; i < 6; i++)
            do_req($sformatf("vec%0d", i), vecs[i].mix, vecs[i].stk, vecs[i].tgt,
                   vecs[i].exp_done, vecs[i].exp_err, vecs[i].exp_presses, 0);

        // second request while busy is ignored
        do_req("busy req ignored", 1, 1'b0, 3'd4, 1'b1, 1'b0, 3, 5);

        // 6-state instance: out-of-range targets and an in-range hit
        do_req6("n6 target6", 3'd6, 1'b0, 1'b1);
        do_req6("n6 target7", 3'd7, 1'b0, 1'b1);
        do_req6("n6 target1", 3'd1, 1'b1, 1'b0);

        // reset during the 5th cycle of a press
        set_mixer(1, 1'b0);
        req_i = 1'b1; target_i = 3'd3;
        k = 0; hi = 0;
        while (hi < 5 && k < 200) begin
            @(negedge clk); k++;
            if (k == 1) req_i = 1'b0;
            if (sw_o) hi++;
        end
        check("mid-press reached 5th cycle", hi, 5);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid-press reset sw_o", int'(sw_o), 0);
        check("mid-press reset busy_o", int'(busy_o), 0);
        check("mid-press reset done_o", int'(done_o), 0);
        check("mid-press reset err_o", int'(err_o), 0);
        check("mid-press reset presses_o", int'(presses_o), 0);
        check("mid-press reset cur_state_o", int'(cur_state_o), 0);
        rst_n = 1'b1;
        sw_seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (sw_o || busy_o) sw_seen++;
        end
        check("no press resumes after reset", sw_seen, 0);
        do_req("post-reset req", 1, 1'b0, 3'd3, 1'b1, 1'b0, 2, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/color_seeker.md
COLOR_SEEKER -- requirements
Module: color_seeker

Interface
REQ-001 Parameter NUM_STATES, default 8, number of states the colour mixer cycles through (2..8).
REQ-002 Parameter PRESS_CYCLES, default 16, clk cycles sw_o is held high per press (>=1).
REQ-003 Parameter GAP_CYCLES, default 32, clk cycles sw_o is held low after each press before LED feedback is sampled (>=2).
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 req_i  input  1  start request; accepted only in IDLE.
REQ-007 target_i  input  3  target state index; sampled on the accepted req_i cycle.
REQ-008 rgb_n_i  input  3  active-low LED feedback from the mixer; bit2=red, bit1=green, bit0=blue.
REQ-009 sw_o  output  1  synthetic button press to the mixer switch input, active-high.
REQ-010 busy_o  output  1  high in every state except IDLE.
REQ-011 done_o  output  1  one-cycle pulse: decoded state equals target.
REQ-012 err_o  output  1  one-cycle pulse: request failed.
REQ-013 presses_o  output  4  presses issued in the current or last request.
REQ-014 cur_state_o  output  3  registered state index decoded from rgb_n_i.

Function
REQ-015 Decode inverted rgb_n_i (colour) to index: 000->0 off, 100->1 red, 010->2 green, 001->3 blue, 110->4 yellow, 011->5 cyan, 101->6 magenta, 111->7 white; register the result into cur_state_o every cycle.
REQ-016 FSM states: IDLE, CHECK, PRESS, GAP, DONE, ERR.
REQ-017 IDLE: on req_i=1, latch target_i, clear presses_o to 0, go to CHECK; if latched target >= NUM_STATES, go to ERR instead.
REQ-018 CHECK (one cycle): cur_state_o == target -> DONE; else if presses_o == NUM_STATES -> ERR; else -> PRESS.
REQ-019 PRESS: sw_o=1 exactly PRESS_CYCLES cycles, presses_o incremented once on entry, then -> GAP.
REQ-020 GAP: sw_o=0 exactly GAP_CYCLES cycles, then -> CHECK.
REQ-021 DONE and ERR each last one cycle, assert done_o or err_o respectively, then -> IDLE.
REQ-022 Latency with target already shown: req_i accepted at cycle N -> done_o at cycle N+2.
REQ-023 req_i while busy_o=1 is ignored; target latch unchanged.
REQ-024 presses_o holds its final value in IDLE until the next accepted request; saturates at NUM_STATES.
REQ-025 done_o and err_o are never high in the same cycle; sw_o is 0 outside PRESS.
REQ-026 A request reaching NUM_STATES presses without a match (mixer unresponsive) ends in err_o, never hangs.

Reset
REQ-027 While rst_n=0 at a rising edge: FSM -> IDLE, sw_o=0, busy_o=0, done_o=0, err_o=0, presses_o=0, cur_state_o=0, timer=0, target latch=0.
REQ-028 Reset mid-PRESS drops sw_o to 0 on the first clock edge with rst_n=0; no partial press resumes after release.

Structure
REQ-029 Shared package color_pkg holds the state-index constants (IDLE_S..WHITE_S), the RGB colour codes (IDLE..WHITE) and the FSM state enum typedef.
REQ-030 One sub-module, cycle_timer: loadable down-counter with done flag, used for PRESS and GAP durations; the decode stays inline.

Verification
REQ-031 Mixer model showing red (rgb_n_i=011), req_i with target_i=1 -> done_o 2 cycles later, presses_o=0, sw_o never high.
REQ-032 Behavioural mixer model at state 1, target_i=4 -> exactly 3 presses each 16 cycles high / 32 low, done_o, presses_o=3.
REQ-033 Mixer at state 7, target_i=0 -> 1 press (wrap-around), done_o, presses_o=1.
REQ-034 rgb_n_i stuck at 111, target_i=2 -> 8 presses then err_o, busy_o falls next cycle, presses_o=8.
REQ-035 NUM_STATES=6, target_i=6 -> err_o 2 cycles after req_i, no press issued.
REQ-036 rst_n=0 during 5th cycle of a press -> sw_o=0 next edge, all outputs at reset values, a new req_i then completes normally.
